// File: rtl/compare_sort_pkg.sv
// compare_sort_pkg: shared types and constants for the compare-sort sequencer
package compare_sort_pkg;
    typedef enum logic [1:0] {IDLE, SORT, FINISH} state_t;
    localparam int SWAP_CNT_W = 8;
endpackage

// File: rtl/compare_sort_ctrl_mag_compare.sv
// mag_compare: unsigned WIDTH-bit magnitude comparator
module mag_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_greater,
    output logic             a_equal,
    output logic             a_less
);
    assign a_greater = a > b;
    assign a_equal   = a == b;
    assign a_less    = a < b;
endmodule

// File: rtl/compare_sort_ctrl.sv
// compare_sort_ctrl: bubble-sort sequencer over a small register file, one shared comparison per clock
module compare_sort_ctrl
    import compare_sort_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       start,
    input  logic                       ascending,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_data,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       busy,
    output logic                       done,
    output logic [SWAP_CNT_W-1:0]      swap_count
);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [IW-1:0]    idx, last;
    logic             asc, swapped;
    logic             gt, eq, lt;

    wire [IW-1:0] idx1     = idx + 1'b1;
    wire          pass_end = idx1 >= last;
    // equal pairs never count as out of order, which keeps the sort stable
    wire          oo       = !eq && (asc ? gt : lt);

    mag_compare #(.WIDTH(WIDTH)) u_cmp (
        .a         (mem[idx]),
        .b         (mem[idx1]),
        .a_greater (gt),
        .a_equal   (eq),
        .a_less    (lt)
    );

    assign rd_data = mem[rd_idx];
    assign full    = count == CNT_W'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count      <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            swap_count <= '0;
            idx        <= '0;
            last       <= '0;
            asc        <= 1'b1;
            swapped    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        count <= '0;
                    end else if (start) begin
                        asc        <= ascending;
                        swap_count <= '0;
                        idx        <= '0;
                        last       <= IW'(count - 1'b1);
                        swapped    <= 1'b0;
                        if (count >= CNT_W'(2)) begin
                            state <= SORT;
                            busy  <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end else if (wr_en && !full) begin
                        mem[count[IW-1:0]] <= wr_data;
                        count              <= count + 1'b1;
                    end
                end
                SORT: begin
                    if (oo) begin
                        mem[idx]   <= mem[idx1];
                        mem[idx1]  <= mem[idx];
                        swapped    <= 1'b1;
                        swap_count <= (&swap_count) ? swap_count : swap_count + 1'b1;
                    end
                    if (!pass_end) begin
                        idx <= idx1;
                    end else if (!(swapped || oo) || last == IW'(1)) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                    end else begin
                        last    <= last - 1'b1;
                        idx     <= '0;
                        swapped <= 1'b0;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_compare_sort_ctrl.sv
// tb_compare_sort_ctrl: directed and random sorts checked against a bubble-sort reference model
module tb_compare_sort_ctrl;
    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 0;
    logic             rst_n = 0;
    logic             clear = 0, wr_en = 0, start = 0, ascending = 1;
    logic [WIDTH-1:0] wr_data = '0;
    logic [1:0]       rd_idx = '0;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] count;
    logic             full, busy, done;
    logic [7:0]       swap_count;

    int errors = 0;
    int checks = 0;
    int mem_m [DEPTH];
    int cnt_m = 0;

    compare_sort_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .start      (start),
        .ascending  (ascending),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .count      (count),
        .full       (full),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic readout(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'(mem_m[i]));
        end
    endtask

    task automatic load(input int v);
        @(negedge clk);
        wr_en = 1; wr_data = 4'(v);
        @(posedge clk); #1;
        wr_en = 0;
        if (cnt_m < DEPTH) begin
            mem_m[cnt_m] = v;
            cnt_m++;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        cnt_m = 0;
        chk("clear count", 32'(count), 0);
    endtask

    // Sorts the model's first cnt_m entries and runs the DUT, comparing latency, swaps and order.
    task automatic run_sort(input string tag, input bit asc, input bit noise);
        int cyc = 0, sc = 0, busy_n, done_k = 0;
        for (int l = cnt_m - 1; l >= 1; l--) begin
            bit sw = 0;
            for (int i = 0; i < l; i++) begin
                cyc++;
                if (asc ? mem_m[i] > mem_m[i+1] : mem_m[i] < mem_m[i+1]) begin
                    int t = mem_m[i];
                    mem_m[i] = mem_m[i+1];
                    mem_m[i+1] = t;
                    sw = 1;
                    sc++;
                end
            end
            if (!sw) break;
        end
        @(negedge clk);
        start = 1; ascending = asc;
        @(posedge clk); #1;
        start = 0; ascending = !asc;
        busy_n = int'(busy);
        if (noise) begin clear = busy; wr_en = busy; wr_data = 4'($urandom_range(0, 15)); end
        for (int k = 1; k <= 100 && done_k == 0; k++) begin
            @(posedge clk); #1;
            if (done) done_k = k;
            else if (busy) busy_n++;
            if (noise) begin clear = busy; wr_en = busy; end
        end
        clear = 0; wr_en = 0;
        chk({tag, " done edge"}, 32'(done_k), 32'(cyc + 1));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(cyc));
        chk({tag, " busy at done"}, 32'(busy), 0);
        chk({tag, " swaps"}, 32'(swap_count), 32'(sc));
        chk({tag, " count kept"}, 32'(count), 32'(cnt_m));
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 32'(done), 0);
        readout(tag);
    endtask

    initial begin
        #3;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset count", 32'(count), 0);
        chk("reset swaps", 32'(swap_count), 0);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        readout("reset");
        @(negedge clk);
        rst_n = 1;

        // worst case descending input
        foreach (mem_m[i]) load(4 - i);
        chk("s1 full", 32'(full), 1);
        run_sort("s1", 1, 0);

        do_clear();
        for (int i = 1; i <= 4; i++) load(i);
        run_sort("s2", 1, 0);

        do_clear();
        load(2); load(7); load(7); load(0);
        run_sort("s3", 0, 0);

        do_clear();
        load(9);
        run_sort("s4", 1, 0);

        // overflow, then clear/wr_en noise while busy
        do_clear();
        for (int i = 0; i < 5; i++) begin
            load(int'($urandom_range(0, 15)));
            chk("s5 count", 32'(count), 32'(cnt_m));
            chk("s5 full", 32'(full), 32'(cnt_m == DEPTH));
        end
        run_sort("s5", 0, 1);

        // reset during the third sort cycle
        do_clear();
        foreach (mem_m[i]) load(4 - i);
        @(negedge clk);
        start = 1; ascending = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("s6 busy", 32'(busy), 0);
        chk("s6 done", 32'(done), 0);
        chk("s6 count", 32'(count), 0);
        chk("s6 swaps", 32'(swap_count), 0);
        cnt_m = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        readout("s6");
        @(negedge clk);
        rst_n = 1;
        run_sort("s6 empty", 1, 0);

        for (int r = 0; r < 20; r++) begin
            int n = int'($urandom_range(0, DEPTH));
            do_clear();
            for (int i = 0; i < n; i++) load(int'($urandom_range(0, 15)));
            run_sort($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
